// File: rtl/sdram_a_ref.sv
// SDRAM auto-refresh controller: requests a refresh slot every interval, then issues
// precharge-all followed by AR_NUM auto-refresh commands with tRP/tRC spacing.
module sdram_a_ref #(
    parameter logic [9:0] CNT_REF_MAX = 10'd749,
    parameter logic [2:0] TRP_CLK     = 3'd2,
    parameter logic [2:0] TRC_CLK     = 3'd7,
    parameter logic [1:0] AR_NUM      = 2'd2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_ba,
    output logic [10:0] aref_addr,
    output logic        aref_end
);

    localparam logic [3:0] CMD_P_CHARGE = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REF = 4'b0001;
    localparam logic [3:0] CMD_NOP      = 4'b0111;

    typedef enum logic [2:0] {
        AREF_IDLE,
        AREF_PCH,
        AREF_TRP,
        AUTO_REF,
        AREF_TRF,
        AREF_END
    } state_t;

    state_t      state;
    logic [9:0]  cnt_ref;
    logic [2:0]  cnt_clk;
    logic [1:0]  cnt_aref;
    logic        ref_wrap;
    logic        grant;

    assign ref_wrap = init_end && (cnt_ref == CNT_REF_MAX);
    assign grant    = (state == AREF_IDLE) && aref_req && aref_en;
    assign aref_end = (state == AREF_END);

    // Interval timer is free-running once init is done, even during a burst.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_ref  <= '0;
            aref_req <= 1'b0;
        end else begin
            if (!init_end || ref_wrap)
                cnt_ref <= '0;
            else
                cnt_ref <= cnt_ref + 10'd1;

            // A wrap on the grant edge keeps the request pending.
            if (ref_wrap)
                aref_req <= 1'b1;
            else if (grant)
                aref_req <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= AREF_IDLE;
            cnt_clk   <= '0;
            cnt_aref  <= '0;
            aref_cmd  <= CMD_NOP;
            aref_ba   <= 2'b11;
            aref_addr <= 11'h7ff;
        end else begin
            aref_ba   <= 2'b11;
            aref_addr <= 11'h7ff;

            // Commands lag their state by one clock.
            case (state)
                AREF_PCH: aref_cmd <= CMD_P_CHARGE;
                AUTO_REF: aref_cmd <= CMD_AUTO_REF;
                default:  aref_cmd <= CMD_NOP;
            endcase

            // Single-cycle states restart the wait counter so each wait state
            // sees the full 0..compare range.
            case (state)
                AREF_IDLE: begin
                    cnt_clk  <= '0;
                    cnt_aref <= '0;
                    if (grant)
                        state <= AREF_PCH;
                end
                AREF_PCH: begin
                    cnt_clk <= '0;
                    state   <= AREF_TRP;
                end
                AREF_TRP: begin
                    if (cnt_clk == TRP_CLK) begin
                        cnt_clk <= '0;
                        state   <= AUTO_REF;
                    end else begin
                        cnt_clk <= cnt_clk + 3'd1;
                    end
                end
                AUTO_REF: begin
                    cnt_clk  <= '0;
                    cnt_aref <= cnt_aref + 2'd1;
                    state    <= AREF_TRF;
                end
                AREF_TRF: begin
                    if (cnt_clk == TRC_CLK) begin
                        cnt_clk <= '0;
                        state   <= (cnt_aref == AR_NUM) ? AREF_END : AUTO_REF;
                    end else begin
                        cnt_clk <= cnt_clk + 3'd1;
                    end
                end
                AREF_END: begin
                    cnt_clk <= '0;
                    state   <= AREF_IDLE;
                end
                default: begin
                    cnt_clk <= '0;
                    state   <= AREF_IDLE;
                end
            endcase
        end
    end

endmodule
